// File: rtl/uart_rx_deframer_pkg.sv
// Shared UART receive-side types and constants.
// Used by the rx deframer and its synchronizer.
package uart_rx_deframer_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_DATA_SIZE  = $clog2(UART_DATA_WIDTH + 1);
    localparam int RX_CLOCK_WIDTH  = 5208;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } UART_RX_FSM;

    typedef struct packed {
        logic                       stop;
        logic                       parity;
        logic [UART_DATA_WIDTH-1:0] data;
    } rx_byte_stop;

    // True when the data byte plus its parity bit do not match the expected sense.
    function automatic logic parity_error(input logic [UART_DATA_WIDTH-1:0] data,
                                          input logic parity_bit,
                                          input logic odd);
        return ((^data) ^ parity_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high serial input.
// Both flops preset to 1 so reset release never looks like a falling edge.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: mid-bit sampling of start, 8 data bits LSB-first, parity and stop,
// with the byte and its status held behind a sticky valid flag.
module uart_rx_deframer
    import uart_rx_deframer_pkg::*;
#(
    parameter int CLKS_PER_BIT = RX_CLOCK_WIDTH,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_i,
    input  logic                       rx_clr,
    output logic [UART_DATA_WIDTH-1:0] rx_data,
    output logic                       rx_valid,
    output logic                       rx_parity_err,
    output logic                       rx_frame_err,
    output logic                       rx_overrun,
    output logic                       rx_busy
);

    localparam int                        CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]          CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [UART_DATA_SIZE-1:0] IDX_LAST = UART_DATA_SIZE'(UART_DATA_WIDTH);

    logic                       w_rx_s;
    logic                       w_fall;
    logic                       w_done;
    logic                       w_perr;
    rx_byte_stop                w_frame;

    UART_RX_FSM                 r_state;
    logic                       r_rx_prev;
    logic [CNT_W-1:0]           r_cnt;
    logic [UART_DATA_SIZE-1:0]  r_idx;
    logic [UART_DATA_WIDTH:0]   r_shift;
    logic [UART_DATA_WIDTH-1:0] r_data;
    logic                       r_valid;
    logic                       r_perr;
    logic                       r_ferr;
    logic                       r_ovr;

    uart_sync2 u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (rx_i),
        .o_sync  (w_rx_s)
    );

    assign w_fall  = r_rx_prev && !w_rx_s;
    assign w_done  = (r_state == RX_STOP) && (r_cnt == CNT_LAST);
    assign w_frame = {w_rx_s, r_shift};
    assign w_perr  = parity_error(w_frame.data, w_frame.parity, PARITY_ODD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_rx_prev <= w_rx_s;

            unique case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[UART_DATA_WIDTH:1]};
                        if (r_idx == IDX_LAST) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_idx <= r_idx + UART_DATA_SIZE'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= RX_IDLE;
                end
            endcase

            // A clear coinciding with completion frees the slot for the new byte.
            if (w_done) begin
                if (!r_valid || rx_clr) begin
                    r_data  <= w_frame.data;
                    r_perr  <= w_perr;
                    r_ferr  <= !w_frame.stop;
                    r_valid <= 1'b1;
                    if (rx_clr) begin
                        r_ovr <= 1'b0;
                    end
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (rx_clr) begin
                r_valid <= 1'b0;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign rx_parity_err = r_perr;
    assign rx_frame_err  = r_ferr;
    assign rx_overrun    = r_ovr;
    assign rx_busy       = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: frames are driven on rx_i, a behavioural
// model predicts each visible output change and a monitor compares as changes appear.
module tb_uart_rx_deframer;

    localparam int CPB  = 50;
    localparam bit PODD = 1'b0;
    // Cycles from pin falling edge to rx_valid visible (10.5 bit times + 3).
    localparam int LAT  = (21 * CPB) / 2 + 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx_i   = 1'b1;
    logic       rx_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    uart_rx_deframer #(
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_i          (rx_i),
        .rx_clr        (rx_clr),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } outRec_t;

    outRec_t model = '0;
    outRec_t expQ[$];
    int      checks   = 0;
    int      failures = 0;

    function automatic outRec_t sampleOut();
        return {rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every change of the visible status must match the next predicted state.
    outRec_t monPrev = '0;
    always @(negedge clk) begin
        outRec_t cur;
        cur = sampleOut();
        if (!rst_n) begin
            monPrev = cur;
        end else if (cur !== monPrev) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_update: got 0x%0h expected no change", cur);
            end else begin
                checkOutput("scoreboard", 32'(cur), 32'(expQ.pop_front()));
            end
            monPrev = cur;
        end
    end

    // Parity bit that makes the frame correct for the configured sense.
    function automatic bit goodParity(input logic [7:0] d);
        return bit'($countones(d) % 2) ^ PODD;
    endfunction

    function automatic bit calcPerr(input logic [7:0] d, input bit p);
        int ones;
        ones = $countones(d) + int'(p);
        return (ones % 2) != int'(PODD);
    endfunction

    task automatic pushIfChanged(input outRec_t next);
        if (next !== model) expQ.push_back(next);
        model = next;
    endtask

    task automatic modelFrame(input logic [7:0] d, input bit p, input bit stop, input bit clr);
        outRec_t next;
        next = model;
        if (!model.valid || clr) begin
            next.data  = d;
            next.perr  = calcPerr(d, p);
            next.ferr  = !stop;
            next.valid = 1'b1;
            if (clr) next.ovr = 1'b0;
        end else begin
            next.ovr = 1'b1;
        end
        pushIfChanged(next);
    endtask

    // Drives one 11-bit frame, one bit per CPB cycles, starting at a negedge.
    task automatic applyStimulus(input logic [7:0] d, input bit p, input bit stop);
        logic [10:0] bits;
        bits = {stop, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_i = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Optionally pulses rx_clr on the exact cycle the stop bit is sampled.
    task automatic sendFrame(input logic [7:0] d, input bit p, input bit stop, input bit clrAtEnd);
        modelFrame(d, p, stop, clrAtEnd);
        if (clrAtEnd) begin
            fork
                applyStimulus(d, p, stop);
                begin
                    repeat (LAT - 1) @(negedge clk);
                    rx_clr = 1'b1;
                    @(negedge clk);
                    rx_clr = 1'b0;
                end
            join
        end else begin
            applyStimulus(d, p, stop);
        end
    endtask

    task automatic pulseClear();
        outRec_t next;
        next       = model;
        next.valid = 1'b0;
        next.perr  = 1'b0;
        next.ferr  = 1'b0;
        next.ovr   = 1'b0;
        pushIfChanged(next);
        rx_clr = 1'b1;
        @(negedge clk);
        rx_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        bit  seen;
        logic [7:0] d;
        logic [7:0] frame5A;

        repeat (3) @(negedge clk);
        checkOutput("reset_state", {20'd0, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Clean byte, latency measured from the pin edge, then a clear.
        n = 0;
        fork
            sendFrame(8'hA5, goodParity(8'hA5), 1'b1, 1'b0);
            begin
                while (!rx_valid && n < LAT + 10) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        checkOutput("latency_window", 32'(n >= LAT - 2 && n <= LAT + 2), 32'd1);
        checkOutput("a5_data", 32'(rx_data), 32'hA5);
        idle(5);
        pulseClear();
        checkOutput("clr_valid", 32'(rx_valid), 32'd0);
        idle(10);

        // Wrong parity.
        sendFrame(8'h01, 1'b0, 1'b1, 1'b0);
        idle(10);
        checkOutput("perr_flag", 32'(rx_parity_err), 32'd1);
        pulseClear();
        idle(10);

        // Short low glitch on an idle line.
        seen = 1'b0;
        rx_i = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rx_busy) seen = 1'b1;
        end
        checkOutput("glitch_armed", 32'(seen), 32'd1);
        idle(60);
        checkOutput("glitch_busy_drop", 32'(rx_busy), 32'd0);
        checkOutput("glitch_no_valid", 32'(rx_valid), 32'd0);

        // Bad stop bit followed by a line held low.
        sendFrame(8'h3C, goodParity(8'h3C), 1'b0, 1'b0);
        repeat (2000) @(negedge clk);
        checkOutput("held_low_no_retrigger", 32'(rx_busy), 32'd0);
        checkOutput("held_low_one_completion", 32'(expQ.size()), 32'd0);
        checkOutput("held_low_ferr", 32'(rx_frame_err), 32'd1);
        idle(20);
        pulseClear();
        idle(10);

        // Back-to-back frames: second one overruns, then a coincident clear replaces.
        sendFrame(8'h11, goodParity(8'h11), 1'b1, 1'b0);
        sendFrame(8'h22, goodParity(8'h22), 1'b1, 1'b0);
        idle(10);
        checkOutput("overrun_keeps_data", 32'(rx_data), 32'h11);
        checkOutput("overrun_flag", 32'(rx_overrun), 32'd1);
        sendFrame(8'h22, goodParity(8'h22), 1'b1, 1'b1);
        idle(10);
        checkOutput("coincident_clr_data", 32'(rx_data), 32'h22);
        checkOutput("coincident_clr_ovr", 32'(rx_overrun), 32'd0);
        checkOutput("coincident_clr_valid", 32'(rx_valid), 32'd1);

        // Reset in the middle of data bit 4.
        frame5A = 8'h5A;
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_i = frame5A[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = frame5A[4];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        model = '0;
        checkOutput("reset_queue_empty", 32'(expQ.size()), 32'd0);
        expQ.delete();
        repeat (3) @(negedge clk);
        checkOutput("reset_mid_frame", {20'd0, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy}, 32'd0);
        rx_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        sendFrame(8'hC3, goodParity(8'hC3), 1'b1, 1'b0);
        idle(10);
        checkOutput("after_reset_data", 32'(rx_data), 32'hC3);

        // Randomized frames with occasional parity/stop errors and clears.
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) pulseClear();
            idle($urandom_range(3, 60));
            sendFrame(d, goodParity(d) ^ ($urandom_range(0, 3) == 0),
                      !($urandom_range(0, 5) == 0), 1'b0);
        end

        idle(20);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
